// File: rtl/riscv_pkg.sv
// Shared RISC-V decode encodings: opcodes, ALU and result-select codes,
// immediate formats, the decoded control bundle and the ID/EX register layout.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    alu_ctrl_e   alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pred_target;
    logic        pred_taken;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } idex_t;

  // sub only exists for R-type; I-ALU callers pass sub = 0.
  function automatic alu_ctrl_e alu_func(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  alu_func = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_func = ALU_AND;
      3'b110:  alu_func = ALU_OR;
      3'b010:  alu_func = ALU_SLT;
      default: alu_func = ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_src_e src);
    case (src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, x0 hard-wired to zero, optional same-cycle writeback bypass.
module register_file #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic        we3,
  input  logic [4:0]  a3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (we3 && (a3 != '0)) begin
      regs[a3] <= wd3;
    end
  end

  // A non-zero source index matching a non-zero write index implies a3 != 0.
  always_comb begin
    if (a1 == '0)                          rd1 = '0;
    else if (BYPASS && we3 && (a3 == a1))  rd1 = wd3;
    else                                   rd1 = regs[a1];
  end

  always_comb begin
    if (a2 == '0)                          rd2 = '0;
    else if (BYPASS && we3 && (a3 == a2))  rd2 = wd3;
    else                                   rd2 = regs[a2];
  end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control decode, immediate extension, register-file read and
// the ID/EX pipeline register with stall/flush.
module decode_cycle
  import riscv_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        PredTakenD,
  input  logic [31:0] PredTargetD,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [31:0] PredTargetE,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic        PredTakenE
);

  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  ctrl_t       ctrl_d;
  imm_src_e    imm_src_d;
  idex_t       idex_d;
  idex_t       idex_q;

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  register_file #(.BYPASS(RF_BYPASS)) u_rf (
    .clk (clk),
    .rst (rst),
    .a1  (Rs1D),
    .a2  (Rs2D),
    .we3 (RegWriteW),
    .a3  (RDW),
    .wd3 (ResultW),
    .rd1 (rd1_d),
    .rd2 (rd2_d)
  );

  // Unknown opcodes leave every control at 0, which is a pipeline bubble.
  always_comb begin
    ctrl_d    = '0;
    imm_src_d = IMM_I;
    case (InstrD[6:0])
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_MEM;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.alu_ctrl   = ALU_ADD;
        imm_src_d         = IMM_I;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
        imm_src_d        = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = alu_func(InstrD[14:12], InstrD[30]);
      end
      OP_IALU: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = alu_func(InstrD[14:12], 1'b0);
        imm_src_d        = IMM_I;
      end
      OP_BRANCH: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
        imm_src_d       = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.result_src = RES_PC4;
        ctrl_d.alu_ctrl   = ALU_ADD;
        imm_src_d         = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    idex_d             = '0;
    idex_d.ctrl        = ctrl_d;
    idex_d.rd1         = rd1_d;
    idex_d.rd2         = rd2_d;
    idex_d.imm         = imm_ext(InstrD, imm_src_d);
    idex_d.pc          = PCD;
    idex_d.pc_plus4    = PCPlus4D;
    idex_d.pred_target = PredTargetD;
    idex_d.pred_taken  = PredTakenD;
    idex_d.rd          = InstrD[11:7];
    idex_d.rs1         = Rs1D;
    idex_d.rs2         = Rs2D;
  end

  // Flush clears the whole register, so it wins over stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else if (!StallD) begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign BranchE     = idex_q.ctrl.branch;
  assign JumpE       = idex_q.ctrl.jump;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign ALUControlE = idex_q.ctrl.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign PredTargetE = idex_q.pred_target;
  assign PredTakenE  = idex_q.pred_taken;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 Parameter RF_BYPASS, default 1, enables the writeback-to-read bypass inside the register file.
REQ-002 clk  in  1  pipeline clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 InstrD  in  32  instruction from fetch.
REQ-005 PCD  in  32  instruction PC.
REQ-006 PCPlus4D  in  32  PC+4.
REQ-007 PredTakenD  in  1  fetch predicted taken.
REQ-008 PredTargetD  in  32  fetch predicted target.
REQ-009 StallD  in  1  hold ID/EX register.
REQ-010 FlushE  in  1  insert bubble into ID/EX register.
REQ-011 RegWriteW  in  1  writeback enable.
REQ-012 RDW  in  5  writeback register index.
REQ-013 ResultW  in  32  writeback data.
REQ-014 Rs1D, Rs2D  out  5 each  combinational source indices for the hazard unit.
REQ-015 RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  out  1 each  registered controls.
REQ-016 ResultSrcE  out  2  00=ALU, 01=memory, 10=PC+4.
REQ-017 ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 RD1E, RD2E, ImmExtE, PCE, PCPlus4E, PredTargetE  out  32 each  registered data.
REQ-019 RdE, Rs1E, Rs2E  out  5 each  registered register indices.
REQ-020 PredTakenE  out  1  registered prediction.

Function
REQ-021 Decode SHALL cover the following opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011, jal 1101111.
REQ-022 Any other opcode SHALL decode to all controls 0, forming a bubble.
REQ-023 Immediates SHALL be sign-extended to 32 bits from instruction bit 31 using the I, S, B or J format selected by opcode, with the B and J formats having LSB = 0.
REQ-024 R-type ALU function: funct3 000 with funct7[5]=1 is sub; otherwise funct3 000/111/110/010 map to add/and/or/slt.
REQ-025 Branch instructions SHALL use sub; load, store and jal SHALL use add.
REQ-026 Register file: 32x32 storage, two combinational read ports, one synchronous write port on posedge clk.
REQ-027 Register x0 SHALL read as 0, and writes to x0 SHALL be ignored.
REQ-028 With RF_BYPASS=1, when RegWriteW=1, RDW!=0 and RDW equals a source index, that port SHALL return ResultW in the same cycle.
REQ-029 The ID/EX register SHALL have a latency of one cycle from the D-stage inputs to the E-stage outputs.
REQ-030 When StallD=1 and FlushE=0, all E-stage outputs SHALL hold their values.
REQ-031 When FlushE=1, on the next edge RegWriteE, MemWriteE, BranchE, JumpE and PredTakenE SHALL be 0; data fields are don't-care.
REQ-032 FlushE SHALL take priority over StallD.
REQ-033 Register-file writes SHALL proceed regardless of StallD and FlushE.
REQ-034 PredTakenD and PredTargetD SHALL pass through unmodified; decode SHALL NOT alter the prediction.

Reset
REQ-035 While rst=0, every E-stage output SHALL be 0 and all 32 registers SHALL be 0.
REQ-036 Reset assertion mid-operation SHALL take effect asynchronously.
REQ-037 After reset, the first rising edge with rst=1 SHALL load normally.

Structure
REQ-038 Opcode constants, ALUControl encodings and ResultSrc encodings SHALL reside in a shared package, riscv_pkg.
REQ-039 The block SHALL contain a single sub-module, register_file, which implements REQ-026 to REQ-028.
REQ-040 Control decode and immediate extension SHALL be combinational logic within decode_cycle.

Verification
REQ-041 Write x5=0x0000_1234 via W port, then add x6,x5,x5 -> RD1E=RD2E=0x1234, ALUControlE=000, RegWriteE=1, RdE=6.
REQ-042 RegWriteW=1, RDW=3, ResultW=0xDEAD_BEEF in the same cycle as InstrD reads x3 -> RD1E=0xDEADBEEF one cycle later.
REQ-043 beq with imm -8 and PredTakenD=1, PredTargetD=0x100 -> ImmExtE=0xFFFF_FFF8, BranchE=1, ALUControlE=001, PredTakenE=1, PredTargetE=0x100.
REQ-044 StallD=1 for 2 cycles with new InstrD -> outputs unchanged; assert StallD and FlushE together -> RegWriteE=MemWriteE=BranchE=JumpE=0.
REQ-045 Write x0=0xFFFF_FFFF, then read x0 -> 0; apply an illegal opcode -> all controls 0.
REQ-046 Drop rst mid-stream -> all E outputs and x1..x31 read 0 immediately, without waiting for a clock edge.
